svd_result_serializer: RTL and testbench
========================================

SVD_RESULT_SERIALIZER -- requirements
Module: svd_result_serializer

Interface
REQ-001 The block SHALL have no parameters; word count (11) and width (32) are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  the 11 SVD result words below are stable and offered for capture.
REQ-005 in_ready  output  1  the block can capture a new result set.
REQ-006 sigma1, sigma2  input  32 each  IEEE-754 single singular values.
REQ-007 u11, u12, u21, u22  input  32 each  IEEE-754 single left singular matrix.
REQ-008 v11, v12, v21, v22  input  32 each  IEEE-754 single right singular matrix.
REQ-009 neg_s  input  32  IEEE-754 single auxiliary sign/scale word.
REQ-010 out_data  output  32  current serialized word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_idx  output  4  index of the current word, 0..10.
REQ-014 out_last  output  1  current word is the last of the frame (idx 10).
REQ-015 out_err  output  1  frame error flag, qualified by out_last.
REQ-016 frame_cnt  output  16  completed-frame count.

Function
REQ-017 The FSM SHALL have two states: IDLE and SEND.
REQ-018 in_ready SHALL be 1 in IDLE and 0 in SEND; a capture occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-019 On capture, all 11 inputs SHALL be registered, idx SHALL be set to 0, and the state SHALL become SEND; inputs are don't-care afterwards.
REQ-020 Word order SHALL be: idx 0 sigma1, 1 sigma2, 2 u11, 3 u12, 4 u21, 5 u22, 6 v11, 7 v12, 8 v21, 9 v22, 10 neg_s.
REQ-021 out_valid SHALL be 1 exactly while in SEND; out_data SHALL equal the captured word at idx; out_data SHALL be 0 in IDLE.
REQ-022 The first word SHALL be valid in the cycle after capture (latency 1).
REQ-023 Each cycle with out_valid and out_ready both 1 SHALL transfer one word; on a transfer at idx < 10, idx SHALL increment.
REQ-024 On a transfer at idx 10, the state SHALL return to IDLE, idx SHALL return to 0, and frame_cnt SHALL increment.
REQ-025 out_data, out_idx, out_last and out_err SHALL hold steady while out_valid=1 and out_ready=0, for any stall length.
REQ-026 out_last SHALL be 1 iff state is SEND and idx is 10.
REQ-027 frame_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 in_valid in SEND SHALL be ignored; no recapture occurs until IDLE is re-entered.
REQ-029 Minimum frame period SHALL be 12 cycles: 1 capture cycle plus 11 transfers.

Reset
REQ-030 When rst_n is asserted, the following SHALL reset immediately and asynchronously: state to IDLE, idx to 0, frame_cnt to 0, captured words to 0, error flag to 0.
REQ-031 Reset outputs SHALL be: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, out_err=0, frame_cnt=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame with no partial completion and no frame_cnt increment.
REQ-033 The first capture after reset deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-034 With macro SVD_SER_NAN_CHECK_EN defined: on capture, an error flag SHALL be set if any captured word has exponent bits [30:23] = 8'hFF (NaN/Inf). out_err SHALL equal flag AND out_last. The flag SHALL clear on the next capture.
REQ-035 With SVD_SER_NAN_CHECK_EN undefined, out_err SHALL be constant 0 and no exponent-check logic SHALL be built.

Verification
REQ-036 Capture sigma1=3fcf1bbd, sigma2=3f1e377a, u/v words 3f800000, neg_s=bf800000, with out_ready=1 -> 11 consecutive words in the REQ-020 order, out_last only on idx 10 (bf800000), frame_cnt=1, in_ready=1 on the next cycle.
REQ-037 Same frame, with out_ready low for 5 cycles at idx 3 -> out_data=3f800000 and out_idx=3 held for all 5 stall cycles; total frame length 16 cycles.
REQ-038 in_valid toggled and inputs changed during SEND -> the serialized words equal the originally captured values; no extra frame.
REQ-039 rst_n pulsed low at idx 6 -> out_valid=0 immediately, frame_cnt=0; the next capture starts at idx 0.
REQ-040 With the macro defined, capture with v21=7fc00000 -> out_err=1 only with out_last; a following clean frame -> out_err=0. With the macro undefined, the same stimulus -> out_err=0 throughout.
REQ-041 With frame_cnt preloaded via 65535 back-to-back frames, complete one more frame -> frame_cnt=16'h0000.

Source files
------------

// File: rtl/svd_result_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | svd_result_serializer                                                    |
// | Captures 11 SVD result words and streams them out one per handshake.     |
// | Optional NaN/Inf frame flag: define SVD_SER_NAN_CHECK_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module svd_result_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sigma1,
  input  logic [31:0] sigma2,
  input  logic [31:0] u11,
  input  logic [31:0] u12,
  input  logic [31:0] u21,
  input  logic [31:0] u22,
  input  logic [31:0] v11,
  input  logic [31:0] v12,
  input  logic [31:0] v21,
  input  logic [31:0] v22,
  input  logic [31:0] neg_s,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        out_err,
  output logic [15:0] frame_cnt
);

  localparam int         C_NUM_WORDS = 11;
  localparam logic [3:0] C_LAST_IDX  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [15:0] r_frame_cnt;
  logic [31:0] w_in_words [C_NUM_WORDS];
  logic [31:0] r_words    [C_NUM_WORDS];
  logic        w_capture;
  logic        w_done;

  // Array position equals the serialized word index.
  assign w_in_words[0]  = sigma1;
  assign w_in_words[1]  = sigma2;
  assign w_in_words[2]  = u11;
  assign w_in_words[3]  = u12;
  assign w_in_words[4]  = u21;
  assign w_in_words[5]  = u22;
  assign w_in_words[6]  = v11;
  assign w_in_words[7]  = v12;
  assign w_in_words[8]  = v21;
  assign w_in_words[9]  = v22;
  assign w_in_words[10] = neg_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 4'd0;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_idx == C_LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_WORDS; i++) r_words[i] <= 32'd0;
    end else if (w_capture) begin
      for (int i = 0; i < C_NUM_WORDS; i++) r_words[i] <= w_in_words[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_comb begin
    out_data = 32'd0;
    if ((r_state == ST_SEND) && (r_idx <= C_LAST_IDX)) begin
      out_data = r_words[r_idx];
    end
  end

  assign out_idx   = r_idx;
  assign out_last  = (r_state == ST_SEND) && (r_idx == C_LAST_IDX);
  assign frame_cnt = r_frame_cnt;

`ifdef SVD_SER_NAN_CHECK_EN
  logic r_err;
  logic w_nan;

  // An all-ones exponent marks NaN or Inf in IEEE-754 single precision.
  always_comb begin
    w_nan = 1'b0;
    for (int i = 0; i < C_NUM_WORDS; i++) begin
      if (w_in_words[i][30:23] == 8'hFF) w_nan = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture) begin
      r_err <= w_nan;
    end
  end

  assign out_err = r_err & out_last;
`else
  assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_svd_result_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_svd_result_serializer                                                 |
// | Directed and randomized checks of the serializer against a frame model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_svd_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] drv [11];
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_err;
  logic [15:0] frame_cnt;

  int n_assert;
  int n_fail;
  int n_valid_cyc;

  // Reference model: a captured frame and the position of the next word to send.
  bit          m_send;
  int          m_pos;
  logic [31:0] m_words [11];
  bit          m_err;
  logic [15:0] m_frames;

  svd_result_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sigma1    (drv[0]),
    .sigma2    (drv[1]),
    .u11       (drv[2]),
    .u12       (drv[3]),
    .u21       (drv[4]),
    .u22       (drv[5]),
    .v11       (drv[6]),
    .v12       (drv[7]),
    .v21       (drv[8]),
    .v22       (drv[9]),
    .neg_s     (drv[10]),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_err   (out_err),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_send   = 1'b0;
    m_pos    = 0;
    m_err    = 1'b0;
    m_frames = 16'd0;
    for (int i = 0; i < 11; i++) m_words[i] = 32'd0;
  endtask

  task automatic model_edge();
    if (rst_n !== 1'b1) begin
      model_reset();
    end else if (!m_send) begin
      if (in_valid) begin
        m_send = 1'b1;
        m_pos  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 11; i++) begin
          m_words[i] = drv[i];
          if (drv[i][30:23] == 8'hFF) m_err = 1'b1;
        end
      end
    end else if (out_ready) begin
      if (m_pos == 10) begin
        m_send   = 1'b0;
        m_pos    = 0;
        m_frames = m_frames + 16'd1;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_idx;
    logic       e_last;
    logic       e_err;
    e_idx  = m_pos[3:0];
    e_last = m_send && (m_pos == 10);
`ifdef SVD_SER_NAN_CHECK_EN
    e_err = e_last && m_err;
`else
    e_err = 1'b0;
`endif
    chk("in_ready",  {31'd0, in_ready},  {31'd0, !m_send});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_send});
    chk("out_data",  out_data, m_send ? m_words[m_pos] : 32'd0);
    chk("out_idx",   {28'd0, out_idx},   {28'd0, e_idx});
    chk("out_last",  {31'd0, out_last},  {31'd0, e_last});
    chk("out_err",   {31'd0, out_err},   {31'd0, e_err});
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frames});
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (out_valid === 1'b1) n_valid_cyc++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 15) == 0) w[30:23] = 8'hFF;
    return w;
  endfunction

  task automatic load_ref_frame();
    drv[0] = 32'h3fcf1bbd;
    drv[1] = 32'h3f1e377a;
    for (int i = 2; i < 10; i++) drv[i] = 32'h3f800000;
    drv[10] = 32'hbf800000;
  endtask

  // Capture the current drive words, then stream the frame to completion.
  task automatic run_frame(input int ready_pct, input bit scramble);
    int guard;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (m_send && guard < 200) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (scramble) begin
        in_valid = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 11; i++) drv[i] = rand_word();
      end
      tick();
      guard++;
    end
    if (guard >= 200) chk("frame_timeout", 32'd1, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int stall;
    int guard;
    n_assert    = 0;
    n_fail      = 0;
    n_valid_cyc = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    for (int i = 0; i < 11; i++) drv[i] = 32'd0;
    model_reset();

    // Reset state, with in_valid asserted to show no capture under reset.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Reference frame at full throughput.
    load_ref_frame();
    run_frame(100, 1'b0);
    chk("ref_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("ref_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Same frame with a 5-cycle stall at word 3.
    load_ref_frame();
    in_valid = 1'b1;
    tick();
    in_valid    = 1'b0;
    n_valid_cyc = 0;
    stall       = 0;
    guard       = 0;
    while (m_send && guard < 60) begin
      if (m_pos == 3 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      tick();
      if (stall > 0 && stall <= 5 && m_pos == 3) begin
        chk("stall_data", out_data, 32'h3f800000);
        chk("stall_idx", {28'd0, out_idx}, 32'd3);
      end
      guard++;
    end
    out_ready = 1'b0;
    chk("stall_frame_len", n_valid_cyc, 32'd16);
    tick();

    // Inputs and in_valid scrambled while sending must not disturb the frame.
    for (int i = 0; i < 11; i++) drv[i] = $urandom;
    run_frame(60, 1'b1);
    repeat (2) tick();

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 11; i++) drv[i] = $urandom;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (m_pos != 6 && guard < 20) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) drv[i] = $urandom;
    run_frame(100, 1'b0);
    tick();

    // NaN in v21, then a clean frame.
    load_ref_frame();
    drv[8] = 32'h7fc00000;
    run_frame(100, 1'b0);
    load_ref_frame();
    run_frame(100, 1'b0);
    tick();

    // Randomized frames with random back-pressure and occasional NaN/Inf words.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 11; i++) drv[i] = rand_word();
      run_frame($urandom_range(30, 100), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Counter wrap from 16'hFFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    m_frames = 16'hFFFF;
    chk("wrap_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 11; i++) drv[i] = $urandom;
    run_frame(100, 1'b0);
    chk("wrap_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
